// File: rtl/thread_block_dispatcher_pkg.sv
// Shared types for the thread-block dispatcher: default-width aliases and the dispatcher FSM state.
package thread_block_dispatcher_pkg;

  localparam int unsigned DefPcWidth       = 16;
  localparam int unsigned DefAddressWidth  = 32;
  localparam int unsigned DefTblockIdxBits = 8;
  localparam int unsigned DefTblockIdBits  = 8;

  typedef logic [DefPcWidth-1:0]       pc_t;
  typedef logic [DefAddressWidth-1:0]  addr_t;
  typedef logic [DefTblockIdxBits-1:0] tblock_idx_t;
  typedef logic [DefTblockIdBits-1:0]  tblock_id_t;

  typedef enum logic [1:0] {
    StIdle,
    StDispatch,
    StDrain,
    StDone
  } disp_state_e;

endpackage

// File: rtl/thread_block_dispatcher_id_pool.sv
// In-flight block ID pool: free bitmap, lowest-free encoder, alloc/free ports.
module tblock_id_pool #(
  parameter int unsigned NumIds = 16,
  parameter int unsigned IdBits = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alloc_i,
  input  logic              free_i,
  input  logic [IdBits-1:0] free_id_i,
  output logic [IdBits-1:0] alloc_id_o,
  output logic              empty_o,
  output logic              free_ok_o
);

  logic [NumIds-1:0] free_q, free_d;

  // Descending scan so the lowest free index wins.
  always_comb begin
    alloc_id_o = '0;
    for (int i = int'(NumIds) - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_id_o = IdBits'(i);
    end
  end

  assign empty_o = ~|free_q;

  // A completion only counts if it names a currently busy ID.
  always_comb begin
    free_ok_o = 1'b0;
    for (int i = 0; i < int'(NumIds); i++) begin
      if (free_id_i == IdBits'(i)) free_ok_o = free_i & ~free_q[i];
    end
  end

  always_comb begin
    free_d = free_q;
    for (int i = 0; i < int'(NumIds); i++) begin
      if (alloc_i && alloc_id_o == IdBits'(i)) free_d[i] = 1'b0;
      if (free_ok_o && free_id_i == IdBits'(i)) free_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) free_q <= '1;
    else         free_q <= free_d;
  end

  spurious_free_a: assert property (@(posedge clk_i) disable iff (!rst_ni) free_i |-> free_ok_o)
    else $warning("spurious tblock completion for id %0d ignored", free_id_i);

endmodule

// File: rtl/thread_block_dispatcher.sv
// Kernel-launch front end: splits a launch into thread blocks, issues them with pooled IDs,
// retires completions and reports kernel completion.
module thread_block_dispatcher
  import thread_block_dispatcher_pkg::*;
#(
  parameter int unsigned PcWidth       = 16,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TblockIdxBits = 8,
  parameter int unsigned TblockIdBits  = 8,
  parameter int unsigned NumTblockIds  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     launch_valid_i,
  output logic                     launch_ready_o,
  input  logic [PcWidth-1:0]       launch_pc_i,
  input  logic [AddressWidth-1:0]  launch_dp_addr_i,
  input  logic [TblockIdxBits:0]   launch_num_tblocks_i,
  output logic                     kernel_done_valid_o,
  input  logic                     kernel_done_ready_i,
  output logic                     busy_o,
  input  logic                     warp_free_i,
  output logic                     allocate_warp_o,
  output logic [PcWidth-1:0]       allocate_pc_o,
  output logic [AddressWidth-1:0]  allocate_dp_addr_o,
  output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
  output logic [TblockIdBits-1:0]  allocate_tblock_id_o,
  input  logic                     tblock_done_i,
  input  logic [TblockIdBits-1:0]  tblock_done_id_i,
  output logic                     tblock_done_ready_o
);

  localparam int unsigned IdxW = TblockIdxBits + 1;
  localparam int unsigned CntW = $clog2(NumTblockIds + 1);
  localparam logic [IdxW-1:0] MaxBlocks = {1'b1, {TblockIdxBits{1'b0}}};

  disp_state_e             state_q, state_d;
  logic [PcWidth-1:0]      pc_q, pc_d;
  logic [AddressWidth-1:0] dp_addr_q, dp_addr_d;
  logic [IdxW-1:0]         num_q, num_d;
  logic [IdxW-1:0]         next_idx_q, next_idx_d;
  logic [CntW-1:0]         inflight_q, inflight_d;
  logic                    pool_empty;
  logic                    retire_ok;

  tblock_id_pool #(
    .NumIds(NumTblockIds),
    .IdBits(TblockIdBits)
  ) u_pool (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .alloc_i   (allocate_warp_o),
    .free_i    (tblock_done_i),
    .free_id_i (tblock_done_id_i),
    .alloc_id_o(allocate_tblock_id_o),
    .empty_o   (pool_empty),
    .free_ok_o (retire_ok)
  );

  assign launch_ready_o        = (state_q == StIdle);
  assign kernel_done_valid_o   = (state_q == StDone);
  assign busy_o                = (state_q != StIdle);
  assign allocate_warp_o       = (state_q == StDispatch) & warp_free_i & ~pool_empty;
  assign allocate_pc_o         = pc_q;
  assign allocate_dp_addr_o    = dp_addr_q;
  assign allocate_tblock_idx_o = next_idx_q[TblockIdxBits-1:0];
  assign tblock_done_ready_o   = 1'b1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dp_addr_d  = dp_addr_q;
    num_d      = num_q;
    next_idx_d = next_idx_q;
    unique case (state_q)
      StIdle: begin
        if (launch_valid_i) begin
          pc_d       = launch_pc_i;
          dp_addr_d  = launch_dp_addr_i;
          num_d      = (launch_num_tblocks_i > MaxBlocks) ? MaxBlocks : launch_num_tblocks_i;
          next_idx_d = '0;
          state_d    = (launch_num_tblocks_i == '0) ? StDone : StDispatch;
        end
      end
      StDispatch: begin
        if (allocate_warp_o) begin
          next_idx_d = next_idx_q + IdxW'(1);
          if (next_idx_d == num_q) state_d = StDrain;
        end
      end
      StDrain: if (inflight_q == '0) state_d = StDone;
      StDone:  if (kernel_done_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Only completions of busy IDs move the counter, so it can never underflow.
  always_comb begin
    inflight_d = inflight_q;
    unique case ({allocate_warp_o, retire_ok})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      dp_addr_q  <= '0;
      num_q      <= '0;
      next_idx_q <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dp_addr_q  <= dp_addr_d;
      num_q      <= num_d;
      next_idx_q <= next_idx_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_thread_block_dispatcher.sv
// Directed bench: a 16-ID dispatcher for the main scenarios and a 2-ID one for pool stalls.
module tb_thread_block_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          tests = 0;
  int          fails = 0;

  // 16-ID instance
  logic        launch_valid = 1'b0, launch_ready, done_valid, done_ready = 1'b0, busy;
  logic [15:0] launch_pc = '0, alloc_pc;
  logic [31:0] launch_dp = '0, alloc_dp;
  logic [8:0]  launch_num = '0;
  logic        warp_free = 1'b0, alloc, tb_done = 1'b0, tb_done_ready;
  logic [7:0]  alloc_idx, alloc_id, tb_done_id = '0;

  // 2-ID instance
  logic        s_launch_valid = 1'b0, s_launch_ready, s_done_valid, s_done_ready = 1'b0, s_busy;
  logic [15:0] s_alloc_pc;
  logic [31:0] s_alloc_dp;
  logic [8:0]  s_launch_num = '0;
  logic        s_warp_free = 1'b0, s_alloc, s_tb_done = 1'b0, s_tb_done_ready;
  logic [7:0]  s_alloc_idx, s_alloc_id, s_tb_done_id = '0;

  always #5 clk = ~clk;

  thread_block_dispatcher dut (
    .clk_i(clk), .rst_ni(rst_n),
    .launch_valid_i(launch_valid), .launch_ready_o(launch_ready),
    .launch_pc_i(launch_pc), .launch_dp_addr_i(launch_dp), .launch_num_tblocks_i(launch_num),
    .kernel_done_valid_o(done_valid), .kernel_done_ready_i(done_ready), .busy_o(busy),
    .warp_free_i(warp_free), .allocate_warp_o(alloc), .allocate_pc_o(alloc_pc),
    .allocate_dp_addr_o(alloc_dp), .allocate_tblock_idx_o(alloc_idx),
    .allocate_tblock_id_o(alloc_id), .tblock_done_i(tb_done), .tblock_done_id_i(tb_done_id),
    .tblock_done_ready_o(tb_done_ready)
  );

  thread_block_dispatcher #(.NumTblockIds(2)) dut_small (
    .clk_i(clk), .rst_ni(rst_n),
    .launch_valid_i(s_launch_valid), .launch_ready_o(s_launch_ready),
    .launch_pc_i(16'h0042), .launch_dp_addr_i(32'h0000_1000), .launch_num_tblocks_i(s_launch_num),
    .kernel_done_valid_o(s_done_valid), .kernel_done_ready_i(s_done_ready), .busy_o(s_busy),
    .warp_free_i(s_warp_free), .allocate_warp_o(s_alloc), .allocate_pc_o(s_alloc_pc),
    .allocate_dp_addr_o(s_alloc_dp), .allocate_tblock_idx_o(s_alloc_idx),
    .allocate_tblock_id_o(s_alloc_id), .tblock_done_i(s_tb_done),
    .tblock_done_id_i(s_tb_done_id), .tblock_done_ready_o(s_tb_done_ready)
  );

  task automatic test_reset();
    #1;
    tests++;
    if ({launch_ready, busy, done_valid, alloc, tb_done_ready} !== 5'b10001) begin
      fails++;
      $display("FAIL reset_ctrl: rdy/busy/done/alloc/tdr=%b want 10001",
               {launch_ready, busy, done_valid, alloc, tb_done_ready});
    end
    tests++;
    if (alloc_pc !== 16'h0 || alloc_dp !== 32'h0 || alloc_idx !== 8'h0) begin
      fails++;
      $display("FAIL reset_data: pc=%h dp=%h idx=%0d want 0/0/0", alloc_pc, alloc_dp, alloc_idx);
    end
    tests++;
    if ({s_launch_ready, s_busy, s_done_valid, s_alloc} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_small: %b want 1000", {s_launch_ready, s_busy, s_done_valid, s_alloc});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_three_blocks();
    @(negedge clk);
    launch_valid = 1'b1; launch_num = 9'd3; launch_pc = 16'h1234; launch_dp = 32'hCAFE_0010;
    #1;
    tests++;
    if (launch_ready !== 1'b1) begin
      fails++; $display("FAIL n3_launch_ready: got %b want 1", launch_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      launch_valid = 1'b0; warp_free = 1'b1; tb_done = (k == 2); tb_done_id = 8'd0;
      #1;
      tests++;
      if (alloc !== 1'b1 || alloc_idx !== 8'(k) || alloc_id !== 8'(k) ||
          alloc_pc !== 16'h1234 || alloc_dp !== 32'hCAFE_0010) begin
        fails++;
        $display("FAIL n3_alloc%0d: warp=%b idx=%0d id=%0d pc=%h dp=%h want 1/%0d/%0d/1234/cafe0010",
                 k, alloc, alloc_idx, alloc_id, alloc_pc, alloc_dp, k, k);
      end
    end
    @(negedge clk);
    tb_done = 1'b1; tb_done_id = 8'd1;
    #1;
    tests++;
    if (alloc !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL n3_drain: alloc=%b busy=%b want 0/1", alloc, busy);
    end
    @(negedge clk);
    tb_done_id = 8'd2;
    @(negedge clk);
    tb_done = 1'b0; warp_free = 1'b0;
    #1;
    tests++;
    if (done_valid !== 1'b0) begin
      fails++; $display("FAIL n3_done_early: got %b want 0", done_valid);
    end
    @(negedge clk);
    #1;
    tests++;
    if (done_valid !== 1'b1) begin
      fails++; $display("FAIL n3_done: got %b want 1", done_valid);
    end
    @(negedge clk);
    done_ready = 1'b1;
    #1;
    tests++;
    if (done_valid !== 1'b1 || launch_ready !== 1'b0) begin
      fails++; $display("FAIL n3_done_hold: done=%b rdy=%b want 1/0", done_valid, launch_ready);
    end
    @(negedge clk);
    done_ready = 1'b0;
    #1;
    tests++;
    if (launch_ready !== 1'b1 || done_valid !== 1'b0) begin
      fails++; $display("FAIL n3_idle: rdy=%b done=%b want 1/0", launch_ready, done_valid);
    end
  endtask

  task automatic test_zero_blocks();
    @(negedge clk);
    launch_valid = 1'b1; launch_num = 9'd0;
    @(negedge clk);
    launch_valid = 1'b0; warp_free = 1'b1;
    #1;
    tests++;
    if (done_valid !== 1'b1 || alloc !== 1'b0) begin
      fails++; $display("FAIL n0_done: done=%b alloc=%b want 1/0", done_valid, alloc);
    end
    @(negedge clk);
    #1;
    tests++;
    if (done_valid !== 1'b1 || launch_ready !== 1'b0) begin
      fails++; $display("FAIL n0_hold: done=%b rdy=%b want 1/0", done_valid, launch_ready);
    end
    @(negedge clk);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0; warp_free = 1'b0;
    #1;
    tests++;
    if (launch_ready !== 1'b1 || done_valid !== 1'b0) begin
      fails++; $display("FAIL n0_idle: rdy=%b done=%b want 1/0", launch_ready, done_valid);
    end
  endtask

  task automatic test_pool_stall();
    logic [7:0] exp_id [5] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd0};
    @(negedge clk);
    s_launch_valid = 1'b1; s_launch_num = 9'd5;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      s_launch_valid = 1'b0; s_warp_free = 1'b1;
      #1;
      tests++;
      if (s_alloc !== 1'b1 || s_alloc_idx !== 8'(k) || s_alloc_id !== exp_id[k]) begin
        fails++;
        $display("FAIL stall_alloc%0d: warp=%b idx=%0d id=%0d want 1/%0d/%0d",
                 k, s_alloc, s_alloc_idx, s_alloc_id, k, exp_id[k]);
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if (s_alloc !== 1'b0) begin
      fails++; $display("FAIL stall_empty: got %b want 0", s_alloc);
    end
    @(negedge clk);
    s_tb_done = 1'b1; s_tb_done_id = 8'd1;
    #1;
    tests++;
    if (s_alloc !== 1'b0) begin
      fails++; $display("FAIL stall_free_same_cycle: got %b want 0", s_alloc);
    end
    // idx 2 on ID 1; retire 1 again; idx 3 on ID 1 while ID 0 retires; idx 4 on ID 0
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      s_tb_done = (k != 4); s_tb_done_id = (k == 3) ? 8'd1 : 8'd0;
      if (k == 2) s_tb_done = 1'b0;
      if (k == 3) s_tb_done_id = 8'd0;
      #1;
      tests++;
      if (s_alloc !== 1'b1 || s_alloc_idx !== 8'(k) || s_alloc_id !== exp_id[k]) begin
        fails++;
        $display("FAIL stall_alloc%0d: warp=%b idx=%0d id=%0d want 1/%0d/%0d",
                 k, s_alloc, s_alloc_idx, s_alloc_id, k, exp_id[k]);
      end
      if (k == 2) begin
        @(negedge clk);
        s_tb_done = 1'b1; s_tb_done_id = 8'd1;
        #1;
        tests++;
        if (s_alloc !== 1'b0) begin
          fails++; $display("FAIL stall_idx3_wait: got %b want 0", s_alloc);
        end
      end
    end
    // Two in flight (IDs 0 and 1) unless the same-cycle alloc/retire miscounted.
    @(negedge clk);
    s_warp_free = 1'b0; s_tb_done = 1'b1; s_tb_done_id = 8'd1;
    @(negedge clk);
    s_tb_done_id = 8'd0;
    @(negedge clk);
    s_tb_done = 1'b0;
    #1;
    tests++;
    if (s_done_valid !== 1'b0) begin
      fails++; $display("FAIL stall_done_early: got %b want 0", s_done_valid);
    end
    @(negedge clk);
    s_done_ready = 1'b1;
    #1;
    tests++;
    if (s_done_valid !== 1'b1) begin
      fails++; $display("FAIL stall_done: got %b want 1", s_done_valid);
    end
    @(negedge clk);
    s_done_ready = 1'b0;
    #1;
    tests++;
    if (s_launch_ready !== 1'b1) begin
      fails++; $display("FAIL stall_idle: got %b want 1", s_launch_ready);
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    launch_valid = 1'b1; launch_num = 9'd2;
    @(negedge clk);
    launch_valid = 1'b0; tb_done = 1'b1; tb_done_id = 8'd5;
    #1;
    tests++;
    if (alloc !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL spur_idle_warp: alloc=%b busy=%b want 0/1", alloc, busy);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tb_done = 1'b0; warp_free = 1'b1;
      #1;
      tests++;
      if (alloc !== 1'b1 || alloc_idx !== 8'(k) || alloc_id !== 8'(k)) begin
        fails++;
        $display("FAIL spur_alloc%0d: warp=%b idx=%0d id=%0d want 1/%0d/%0d",
                 k, alloc, alloc_idx, alloc_id, k, k);
      end
    end
    @(negedge clk);
    warp_free = 1'b0; tb_done = 1'b1; tb_done_id = 8'd0;
    @(negedge clk);
    tb_done_id = 8'd1;
    @(negedge clk);
    tb_done = 1'b0;
    @(negedge clk);
    done_ready = 1'b1;
    #1;
    tests++;
    if (done_valid !== 1'b1) begin
      fails++; $display("FAIL spur_done: got %b want 1", done_valid);
    end
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  task automatic test_reset_in_drain();
    @(negedge clk);
    launch_valid = 1'b1; launch_num = 9'd4; launch_pc = 16'hBEEF; launch_dp = 32'h8000_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      launch_valid = 1'b0; warp_free = 1'b1;
    end
    @(negedge clk);
    warp_free = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b1 || alloc !== 1'b0 || done_valid !== 1'b0) begin
      fails++; $display("FAIL rst_drain_state: busy=%b alloc=%b done=%b want 1/0/0",
                        busy, alloc, done_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({launch_ready, busy, done_valid, alloc} !== 4'b1000 ||
        alloc_pc !== 16'h0 || alloc_dp !== 32'h0 || alloc_idx !== 8'h0) begin
      fails++;
      $display("FAIL rst_drain_outputs: ctrl=%b pc=%h dp=%h idx=%0d want 1000/0/0/0",
               {launch_ready, busy, done_valid, alloc}, alloc_pc, alloc_dp, alloc_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch_valid = 1'b1; launch_num = 9'd1; launch_pc = 16'h00A5;
    @(negedge clk);
    launch_valid = 1'b0; warp_free = 1'b1;
    #1;
    tests++;
    if (alloc !== 1'b1 || alloc_idx !== 8'd0 || alloc_id !== 8'd0 || alloc_pc !== 16'h00A5) begin
      fails++; $display("FAIL rst_relaunch_alloc: warp=%b idx=%0d id=%0d pc=%h want 1/0/0/00a5",
                        alloc, alloc_idx, alloc_id, alloc_pc);
    end
    @(negedge clk);
    warp_free = 1'b0; tb_done = 1'b1; tb_done_id = 8'd0;
    @(negedge clk);
    tb_done = 1'b0;
    #1;
    tests++;
    if (done_valid !== 1'b0) begin
      fails++; $display("FAIL rst_relaunch_early: got %b want 0", done_valid);
    end
    @(negedge clk);
    done_ready = 1'b1;
    #1;
    tests++;
    if (done_valid !== 1'b1) begin
      fails++; $display("FAIL rst_relaunch_done: got %b want 1", done_valid);
    end
    @(negedge clk);
    done_ready = 1'b0;
    #1;
    tests++;
    if (launch_ready !== 1'b1) begin
      fails++; $display("FAIL rst_relaunch_idle: got %b want 1", launch_ready);
    end
  endtask

  initial begin
    test_reset();
    test_three_blocks();
    test_zero_blocks();
    test_pool_stall();
    test_spurious();
    test_reset_in_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
